// File: rtl/bus_register_file.sv
// bus_register_file: sixteen DATA_W-bit general registers loaded from a shared
// bus. A register is selected either through the one-hot direct enables or by
// decoding ra/rb/rc from the instruction word. Exactly one selected target per
// cycle produces a write. Two or more distinct targets produce no write and set
// a sticky conflict flag instead. A saturating write counter and the index of
// the last register written are also kept.
//
// Optional build macro: BUS_REGISTER_FILE_R0_ZERO_EN
//   When defined, BusMuxInR0 reads as zero whenever BAout=1, which gives
//   base-address arithmetic a hard zero. R0 storage is still written normally.
//   When undefined, BusMuxInR0 always shows R0 storage.
module bus_register_file #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic [15:0]       Rdirect_in,
  input  logic [31:0]       IR,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  output logic [DATA_W-1:0] BusMuxInR0,
  output logic [DATA_W-1:0] BusMuxInR1,
  output logic [DATA_W-1:0] BusMuxInR2,
  output logic [DATA_W-1:0] BusMuxInR3,
  output logic [DATA_W-1:0] BusMuxInR4,
  output logic [DATA_W-1:0] BusMuxInR5,
  output logic [DATA_W-1:0] BusMuxInR6,
  output logic [DATA_W-1:0] BusMuxInR7,
  output logic [DATA_W-1:0] BusMuxInR8,
  output logic [DATA_W-1:0] BusMuxInR9,
  output logic [DATA_W-1:0] BusMuxInR10,
  output logic [DATA_W-1:0] BusMuxInR11,
  output logic [DATA_W-1:0] BusMuxInR12,
  output logic [DATA_W-1:0] BusMuxInR13,
  output logic [DATA_W-1:0] BusMuxInR14,
  output logic [DATA_W-1:0] BusMuxInR15,
  output logic [15:0]       Rout_sel,
  output logic              wr_conflict,
  output logic [CNT_W-1:0]  wr_count,
  output logic [3:0]        last_wr_idx
);

  logic [DATA_W-1:0] r_regs [16];
  logic              r_wr_conflict;
  logic [CNT_W-1:0]  r_wr_count;
  logic [3:0]        r_last_wr_idx;

  logic [3:0]  w_idx;
  logic        w_idx_valid;
  logic [15:0] w_dec_vec;
  logic [15:0] w_wr_vec;
  logic        w_single;
  logic        w_multi;
  logic [3:0]  w_wr_idx;
  logic        w_unused_ir;

  // Only the three register fields of the instruction word matter here.
  assign w_unused_ir = ^{IR[31:27], IR[14:0]};

  // Register-field select with priority ra over rb over rc.
  always_comb begin
    w_idx       = 4'd0;
    w_idx_valid = 1'b1;
    if (Gra)      w_idx = IR[26:23];
    else if (Grb) w_idx = IR[22:19];
    else if (Grc) w_idx = IR[18:15];
    else          w_idx_valid = 1'b0;
  end

  // A direct enable and a decoded write to the same register merge into one write.
  assign w_dec_vec = (Rin && w_idx_valid) ? (16'h0001 << w_idx) : 16'h0000;
  assign w_wr_vec  = Rdirect_in | w_dec_vec;
  assign w_single  = (w_wr_vec != 16'h0000) && ((w_wr_vec & (w_wr_vec - 16'h0001)) == 16'h0000);
  assign w_multi   = (w_wr_vec != 16'h0000) && !w_single;

  // Encode the single set bit of the write vector into a register index.
  always_comb begin
    w_wr_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_wr_vec[i]) w_wr_idx = 4'(i);
    end
  end

  // Register storage, saturating write counter, last index and sticky conflict flag.
  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_wr_conflict <= 1'b0;
      r_wr_count    <= '0;
      r_last_wr_idx <= 4'd0;
    end else if (w_single) begin
      r_regs[w_wr_idx] <= BusMuxOut;
      r_last_wr_idx    <= w_wr_idx;
      if (r_wr_count != {CNT_W{1'b1}}) r_wr_count <= r_wr_count + 1'b1;
    end else if (w_multi) begin
      r_wr_conflict <= 1'b1;
    end
  end

  assign Rout_sel    = ((Rout || BAout) && w_idx_valid) ? (16'h0001 << w_idx) : 16'h0000;
  assign wr_conflict = r_wr_conflict;
  assign wr_count    = r_wr_count;
  assign last_wr_idx = r_last_wr_idx;

`ifdef BUS_REGISTER_FILE_R0_ZERO_EN
  assign BusMuxInR0  = BAout ? '0 : r_regs[0];
`else
  assign BusMuxInR0  = r_regs[0];
`endif
  assign BusMuxInR1  = r_regs[1];
  assign BusMuxInR2  = r_regs[2];
  assign BusMuxInR3  = r_regs[3];
  assign BusMuxInR4  = r_regs[4];
  assign BusMuxInR5  = r_regs[5];
  assign BusMuxInR6  = r_regs[6];
  assign BusMuxInR7  = r_regs[7];
  assign BusMuxInR8  = r_regs[8];
  assign BusMuxInR9  = r_regs[9];
  assign BusMuxInR10 = r_regs[10];
  assign BusMuxInR11 = r_regs[11];
  assign BusMuxInR12 = r_regs[12];
  assign BusMuxInR13 = r_regs[13];
  assign BusMuxInR14 = r_regs[14];
  assign BusMuxInR15 = r_regs[15];

endmodule

// File: tb/tb_bus_register_file.sv
// Testbench for bus_register_file: directed steps followed by a randomized
// phase, each checked against a behavioural model of the register file.
module tb_bus_register_file;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic [DATA_W-1:0] bus = '0;
  logic [15:0]       rdirect = '0;
  logic [31:0]       ir = '0;
  logic              gra = 0, grb = 0, grc = 0, rin = 0, rout = 0, baout = 0;

  logic [DATA_W-1:0] r_out [16];
  logic [15:0]       rout_sel;
  logic              wr_conflict;
  logic [CNT_W-1:0]  wr_count;
  logic [3:0]        last_wr_idx;

  always #5 clock = ~clock;

  bus_register_file #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(bus), .Rdirect_in(rdirect), .IR(ir),
    .Gra(gra), .Grb(grb), .Grc(grc), .Rin(rin), .Rout(rout), .BAout(baout),
    .BusMuxInR0(r_out[0]),   .BusMuxInR1(r_out[1]),   .BusMuxInR2(r_out[2]),   .BusMuxInR3(r_out[3]),
    .BusMuxInR4(r_out[4]),   .BusMuxInR5(r_out[5]),   .BusMuxInR6(r_out[6]),   .BusMuxInR7(r_out[7]),
    .BusMuxInR8(r_out[8]),   .BusMuxInR9(r_out[9]),   .BusMuxInR10(r_out[10]), .BusMuxInR11(r_out[11]),
    .BusMuxInR12(r_out[12]), .BusMuxInR13(r_out[13]), .BusMuxInR14(r_out[14]), .BusMuxInR15(r_out[15]),
    .Rout_sel(rout_sel), .wr_conflict(wr_conflict), .wr_count(wr_count), .last_wr_idx(last_wr_idx)
  );

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [16];
  int                m_count;
  int                m_last;
  bit                m_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  // Register named by the instruction fields, or -1 when no field is selected.
  function automatic int sel_reg();
    if (gra) return int'(ir[26:23]);
    if (grb) return int'(ir[22:19]);
    if (grc) return int'(ir[18:15]);
    return -1;
  endfunction

  function automatic logic [15:0] exp_rout_sel();
    int r;
    r = sel_reg();
    if ((rout || baout) && r >= 0) return 16'(1 << r);
    return 16'h0000;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    int targets[$];
    int r;
    if (clear) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_count = 0; m_last = 0; m_conflict = 0;
      return;
    end
    for (int i = 0; i < 16; i++) if (rdirect[i]) targets.push_back(i);
    r = sel_reg();
    if (rin && r >= 0) begin
      bit seen = 0;
      foreach (targets[k]) if (targets[k] == r) seen = 1;
      if (!seen) targets.push_back(r);
    end
    if (targets.size() == 1) begin
      m_mem[targets[0]] = bus;
      m_last = targets[0];
      if (m_count < (1 << CNT_W) - 1) m_count++;
    end else if (targets.size() > 1) begin
      m_conflict = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_r0_view();
`ifdef BUS_REGISTER_FILE_R0_ZERO_EN
    if (baout) return '0;
`endif
    return m_mem[0];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ":R0"}, 64'(r_out[0]), 64'(exp_r0_view()));
    for (int i = 1; i < 16; i++) check($sformatf("%s:R%0d", tag, i), 64'(r_out[i]), 64'(m_mem[i]));
    check({tag, ":rout_sel"}, 64'(rout_sel), 64'(exp_rout_sel()));
    check({tag, ":wr_conflict"}, 64'(wr_conflict), 64'(m_conflict));
    check({tag, ":wr_count"}, 64'(wr_count), 64'(m_count));
    check({tag, ":last_wr_idx"}, 64'(last_wr_idx), 64'(m_last));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    clear = 0; rdirect = '0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
  endtask

  function automatic logic [31:0] mk_ir(input int ra, input int rb, input int rc);
    logic [31:0] v;
    v = $urandom;
    v[26:23] = 4'(ra); v[22:19] = 4'(rb); v[18:15] = 4'(rc);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    m_count = 0; m_last = 0; m_conflict = 0;

    // Reset state
    #1;
    idle(); clear = 1; tick(); clear = 0;
    check_all("reset");

    // Write via decode: ra=5
    ir = mk_ir(5, 1, 2); gra = 1; rin = 1; bus = 32'hDEADBEEF;
    tick(); idle();
    check("decode_write:R5", 64'(r_out[5]), 64'h0000_0000_DEAD_BEEF);
    check("decode_write:count", 64'(wr_count), 64'd1);
    check("decode_write:last", 64'(last_wr_idx), 64'd5);
    check_all("decode_write");

    // Priority decode Gra over Grb on the read select
    ir = mk_ir(2, 7, 9); gra = 1; grb = 1; rout = 1; #1;
    check("priority:rout_sel", 64'(rout_sel), 64'h0004);
    gra = 0; #1;
    check("priority_rb:rout_sel", 64'(rout_sel), 64'h0080);
    grb = 0; grc = 1; rout = 0; baout = 1; #1;
    check("priority_rc_ba:rout_sel", 64'(rout_sel), 64'h0200);
    grc = 0; #1;
    check("no_field:rout_sel", 64'(rout_sel), 64'h0000);
    idle();

    // Conflict: direct R3 plus decoded R9
    ir = mk_ir(9, 0, 0); gra = 1; rin = 1; rdirect = 16'h0008; bus = 32'h55;
    tick(); idle();
    check("conflict:flag", 64'(wr_conflict), 64'd1);
    check("conflict:count_hold", 64'(wr_count), 64'd1);
    check("conflict:last_hold", 64'(last_wr_idx), 64'd5);
    for (int k = 0; k < 3; k++) tick();
    check("conflict_sticky:flag", 64'(wr_conflict), 64'd1);
    check_all("conflict_idle");

    // Clear, then same-target merge on R9
    clear = 1; tick(); clear = 0;
    check_all("clear_after_conflict");
    ir = mk_ir(0, 9, 0); grb = 1; rin = 1; rdirect = 16'h0200; bus = 32'h12;
    tick(); idle();
    check("merge:R9", 64'(r_out[9]), 64'h12);
    check("merge:flag", 64'(wr_conflict), 64'd0);
    check_all("merge");

    // Reset beats write
    clear = 1; rdirect = 16'h0001; bus = 32'hFFFF_FFFF;
    tick(); idle();
    check("reset_wins:R0", 64'(r_out[0]), 64'd0);
    check("reset_wins:count", 64'(wr_count), 64'd0);

    // R0 writable; BAout view depends on the build
    rdirect = 16'h0001; bus = 32'h44;
    tick(); idle();
    check("r0_store:R0", 64'(r_out[0]), 64'h44);
    baout = 1; #1;
`ifdef BUS_REGISTER_FILE_R0_ZERO_EN
    check("r0_baout:R0", 64'(r_out[0]), 64'h0);
`else
    check("r0_baout:R0", 64'(r_out[0]), 64'h44);
`endif
    check_all("r0_baout");
    idle();

    // Clear mid-sequence discards the pending decoded write
    ir = mk_ir(0, 0, 6); grc = 1; rin = 1; bus = 32'hA5A5_A5A5; clear = 1;
    tick(); idle();
    check("clear_pending:R6", 64'(r_out[6]), 64'd0);
    check_all("clear_pending");

    // Randomized phase, long enough to drive the counter into saturation
    for (int n = 0; n < 600; n++) begin
      int mode;
      mode = $urandom_range(0, 9);
      ir = $urandom; bus = $urandom;
      gra = 1'($urandom); grb = 1'($urandom); grc = 1'($urandom);
      rout = 1'($urandom); baout = 1'($urandom);
      rin = 0; rdirect = '0;
      if (mode >= 1 && mode <= 6) begin
        rdirect = 16'(1 << $urandom_range(0, 15));
      end else if (mode == 7 || mode == 8) begin
        rin = 1;
      end else if (mode == 9) begin
        rdirect = 16'($urandom); rin = 1;
      end
      #1;
      check("rand:rout_sel", 64'(rout_sel), 64'(exp_rout_sel()));
      tick();
      check_all("rand");
    end
    idle(); #1;
    check("saturate:count", 64'(wr_count), 64'hFF);

    // One more direct write must not wrap the counter
    rdirect = 16'h8000; bus = 32'h7;
    tick(); idle();
    check("saturate_hold:count", 64'(wr_count), 64'hFF);
    check("saturate_hold:last", 64'(last_wr_idx), 64'd15);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion, required completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_register_file.md
BUS_REGISTER_FILE -- requirements
Module: bus_register_file

Interface
REQ-001 Parameter DATA_W, default 32: register and bus data width.
REQ-002 Parameter CNT_W, default 8: width of the write counter.
REQ-003 Port clock, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 Port clear, input, 1: reset, synchronous and active-high.
REQ-005 Port BusMuxOut, input, DATA_W: the shared bus value to be captured.
REQ-006 Port Rdirect_in, input, 16: one-hot direct load enables, bit n is R{n}in.
REQ-007 Port IR, input, 32: instruction fields ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-008 Ports Gra, Grb, Grc, Rin, Rout, BAout, input, 1 each: select-and-encode controls.
REQ-009 Ports BusMuxInR0 through BusMuxInR15, output, DATA_W each: register contents driven toward the bus mux.
REQ-010 Port Rout_sel, output, 16: one-hot R{n}out request toward the bus encoder.
REQ-011 Port wr_conflict, output, 1: sticky multi-writer error flag.
REQ-012 Port wr_count, output, CNT_W: count of successful write cycles.
REQ-013 Port last_wr_idx, output, 4: index of the most recently written register.

Function
REQ-014 The decoded index SHALL be ra if Gra=1, else rb if Grb=1, else rc if Grc=1, else invalid; priority is Gra > Grb > Grc.
REQ-015 The effective write vector SHALL be Rdirect_in OR (Rin AND valid index ? one-hot(index) : 0).
REQ-016 If the write vector has exactly one bit set, that register SHALL load BusMuxOut at the rising edge, giving 1-cycle latency, and wr_count SHALL increment.
REQ-017 On a successful write, last_wr_idx SHALL take the index of the register written.
REQ-018 If the write vector has two or more bits set, no register SHALL be written, wr_count and last_wr_idx SHALL hold, and wr_conflict SHALL be set.
REQ-019 Once set, wr_conflict SHALL remain 1 until clear.
REQ-020 If the write vector is zero, all state SHALL hold.
REQ-021 wr_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-022 Rout_sel SHALL be combinational: one-hot(index) when (Rout OR BAout) and the index is valid, else all zeros.
REQ-023 Each BusMuxInRn SHALL show the stored value, so a write becomes visible the cycle after the edge; there is no write-through.
REQ-024 Rdirect_in and the decoded write in the same cycle SHALL be a single write if they target the same register, and a conflict otherwise.

Reset
REQ-025 When clear=1 at an edge, all 16 registers, wr_count, last_wr_idx and wr_conflict SHALL become 0.
REQ-026 clear SHALL take priority over any write in the same cycle.
REQ-027 Asserting clear mid-sequence SHALL discard the pending write.

Configuration
REQ-028 With macro BUS_REGISTER_FILE_R0_ZERO_EN defined, BusMuxInR0 SHALL read 0 whenever BAout=1, and R0 storage otherwise.
REQ-029 With BUS_REGISTER_FILE_R0_ZERO_EN undefined, BusMuxInR0 SHALL always show R0 storage.
REQ-030 In both builds, R0 SHALL be writable like any other register.

Verification
REQ-031 Write via decode: IR ra=5, Gra=1, Rin=1, BusMuxOut=0xDEADBEEF, one edge -> BusMuxInR5=0xDEADBEEF next cycle, wr_count=1, last_wr_idx=5.
REQ-032 Priority decode: ra=2, rb=7, Gra=1, Grb=1, Rout=1 -> Rout_sel=0x0004.
REQ-033 Conflict: Rdirect_in=0x0008 with decoded Rin to R9, BusMuxOut=0x55 -> R3 and R9 unchanged, wr_conflict=1 and remains 1 after 3 idle cycles.
REQ-034 Same-target merge: Rdirect_in=0x0200 with decoded Rin to R9, BusMuxOut=0x12 -> R9=0x12, wr_conflict=0.
REQ-035 Reset beats write: clear=1 with Rdirect_in=0x0001, BusMuxOut=0xFFFFFFFF -> R0=0, wr_count=0.
REQ-036 Macro build: R0=0x44, BAout=1 -> BusMuxInR0=0 with the macro defined, and 0x44 without it.
